// File: rtl/mem_pipe_sched_pkg.sv
// Shared definitions for the memory pipeline scheduler.
// Holds the FSM state encoding, the tag width constant for the default
// requester count and a width helper used by the scheduler and its bench.
package mem_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_FREE = 2'd2
    } state_t;

    // Width needed to index n items; never returns less than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_REQ_DEFAULT = 4;
    localparam int TAG_W         = clog2_min1(N_REQ_DEFAULT);

endpackage

// File: rtl/mem_pipe_sched_if.sv
// Requester-side bus of the memory pipeline scheduler.
//   i_req  : level request per requester
//   i_addr : per-requester address, slice k belongs to requester k
//   i_we   : per-requester write enable
//   o_gnt  : one-hot, one-cycle grant pulse
//   o_done : one-hot, one-cycle completion pulse
// Handshake: a requester raises i_req with stable i_addr/i_we and holds all
// three until it sees its o_gnt bit for one cycle; the grant cycle is the
// transfer, after which it may drop or re-raise i_req. o_done[k] later
// reports that requester k's oldest outstanding token left the pipeline.
interface mem_pipe_sched_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 10
);
    logic [N_REQ-1:0]        i_req;
    logic [N_REQ*ADDR_W-1:0] i_addr;
    logic [N_REQ-1:0]        i_we;
    logic [N_REQ-1:0]        o_gnt;
    logic [N_REQ-1:0]        o_done;

    modport master (
        output i_req, i_addr, i_we,
        input  o_gnt, o_done
    );

    modport slave (
        input  i_req, i_addr, i_we,
        output o_gnt, o_done
    );
endinterface

// File: rtl/mem_pipe_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   gnt   : one-hot grant of the first requester at or after ptr
//   idx   : index of that requester
//   valid : some requester won
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int sel;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        sel   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            sel = (int'(ptr) + i) % N_REQ;
            if (!valid && req[sel]) begin
                valid    = 1'b1;
                gnt[sel] = 1'b1;
                idx      = IDX_W'(sel);
            end
        end
    end

endmodule

// File: rtl/mem_pipe_sched.sv
// Scheduler sharing one two-stage click memory pipeline among N_REQ
// requesters. Round-robin arbitration, one launch per grant, in-flight
// tracking from the pipeline's free/fire/done pulses and per-requester
// completion pulses in launch order.
//   clk, rst       : clock, asynchronous active-low reset
//   bus            : requester side (req/addr/we in, gnt/done out)
//   o_drive        : one-cycle launch pulse to the pipeline
//   o_addr, o_we   : attributes of the last launched token
//   i_free         : sender accepted the launch
//   i_fire[1:0]    : relay0 / relay1 fired
//   i_done         : token left the pipeline
//   o_busy         : tokens in flight or FSM not idle
//   o_err          : sticky protocol error
//   o_dbg_state    : FSM state
//   o_dbg_inflight : tokens currently in flight
module mem_pipe_sched
    import mem_pipe_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int ADDR_W       = 10,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_pipe_sched_if.slave   bus,
    output logic              o_drive,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we,
    input  logic              i_free,
    input  logic [1:0]        i_fire,
    input  logic              i_done,
    output logic              o_busy,
    output logic              o_err,
    output state_t            o_dbg_state,
    output logic [1:0]        o_dbg_inflight
);

    localparam int TW = clog2_min1(N_REQ);
    localparam int PW = clog2_min1(MAX_INFLIGHT);

    state_t           state, state_nx;
    logic [TW-1:0]    rr_ptr;
    logic [TW-1:0]    win_idx;
    logic [1:0]       inflight;
    logic [1:0]       fifo_cnt;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [TW-1:0]    tag_mem [MAX_INFLIGHT];
    logic             s0, s1;
    logic [N_REQ-1:0] done_q;

    logic [N_REQ-1:0] arb_gnt;
    logic [TW-1:0]    arb_idx;
    logic             arb_valid;

    logic             start, launch, done_ok;
    logic             s0_nx, s1_nx, stage_err;
    logic             err_event;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(TW)) u_arb (
        .req   (bus.i_req),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Arbitration is gated by both the credit count and FIFO space: a tag is
    // pushed one cycle before inflight counts the launch.
    assign start   = (state == IDLE) && arb_valid &&
                     (inflight < 2'(MAX_INFLIGHT)) && (fifo_cnt < 2'(MAX_INFLIGHT));
    assign launch  = (state == LAUNCH);
    assign done_ok = i_done && (inflight != 2'd0) && (fifo_cnt != 2'd0);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (start)  state_nx = LAUNCH;
            LAUNCH:                state_nx = WAIT_FREE;
            WAIT_FREE: if (i_free) state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    // Stage events are applied as done, then fire1, then fire0 so a token can
    // advance through every stage boundary in one cycle.
    always_comb begin
        s0_nx     = s0;
        s1_nx     = s1;
        stage_err = 1'b0;
        if (i_done) begin
            if (!s1_nx) stage_err = 1'b1;
            s1_nx = 1'b0;
        end
        if (i_fire[1]) begin
            if (!s0_nx || s1_nx) stage_err = 1'b1;
            s0_nx = 1'b0;
            s1_nx = 1'b1;
        end
        if (i_fire[0]) begin
            if (s0_nx) stage_err = 1'b1;
            s0_nx = 1'b1;
        end
    end

    assign err_event = stage_err || (i_free && (state != WAIT_FREE)) ||
                       (i_done && !done_ok);

    assign o_drive        = launch;
    assign bus.o_gnt      = launch ? (N_REQ'(1) << win_idx) : '0;
    assign bus.o_done     = done_q;
    assign o_busy         = (inflight != 2'd0) || (state != IDLE);
    assign o_dbg_state    = state;
    assign o_dbg_inflight = inflight;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            win_idx  <= '0;
            inflight <= 2'd0;
            fifo_cnt <= 2'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            s0       <= 1'b0;
            s1       <= 1'b0;
            done_q   <= '0;
            o_addr   <= '0;
            o_we     <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state <= state_nx;
            s0    <= s0_nx;
            s1    <= s1_nx;
            if (err_event) o_err <= 1'b1;

            if (start) begin
                win_idx <= arb_idx;
                o_addr  <= bus.i_addr[arb_idx*ADDR_W +: ADDR_W];
                o_we    <= bus.i_we[arb_idx];
                wr_ptr  <= (wr_ptr == PW'(MAX_INFLIGHT-1)) ? '0 : wr_ptr + 1'b1;
            end

            if (launch)
                rr_ptr <= (win_idx == TW'(N_REQ-1)) ? '0 : win_idx + 1'b1;

            if (done_ok) begin
                done_q <= N_REQ'(1) << tag_mem[rd_ptr];
                rd_ptr <= (rd_ptr == PW'(MAX_INFLIGHT-1)) ? '0 : rd_ptr + 1'b1;
            end else begin
                done_q <= '0;
            end

            fifo_cnt <= fifo_cnt + 2'(start) - 2'(done_ok);

            if (launch && !done_ok && (inflight < 2'(MAX_INFLIGHT)))
                inflight <= inflight + 2'd1;
            else if (!launch && done_ok)
                inflight <= inflight - 2'd1;
        end
    end

    // Tag storage needs no reset: the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (start) tag_mem[wr_ptr] <= arb_idx;
    end

endmodule

// File: tb/tb_mem_pipe_sched.sv
// Directed bench for mem_pipe_sched (N_REQ=4, ADDR_W=10, MAX_INFLIGHT=2).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_pipe_sched;
    import mem_pipe_pkg::*;

    logic       clk;
    logic       rst;
    logic       i_free;
    logic [1:0] i_fire;
    logic       i_done;
    logic       o_drive;
    logic [9:0] o_addr;
    logic       o_we;
    logic       o_busy;
    logic       o_err;
    state_t     dbg_state;
    logic [1:0] dbg_inflight;

    int checks = 0;
    int errors = 0;

    mem_pipe_sched_if #(.N_REQ(4), .ADDR_W(10)) bus ();

    mem_pipe_sched #(.N_REQ(4), .ADDR_W(10), .MAX_INFLIGHT(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .o_drive        (o_drive),
        .o_addr         (o_addr),
        .o_we           (o_we),
        .i_free         (i_free),
        .i_fire         (i_fire),
        .i_done         (i_done),
        .o_busy         (o_busy),
        .o_err          (o_err),
        .o_dbg_state    (dbg_state),
        .o_dbg_inflight (dbg_inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        bus.i_req  = '0;
        bus.i_we   = '0;
        i_free     = 1'b0;
        i_fire     = 2'b00;
        i_done     = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // One token through both relays and out; returns with the o_done pulse visible.
    task automatic flush_one(input string tag, input logic [3:0] exp_done);
        i_fire = 2'b01; step();
        i_fire = 2'b10; step();
        i_fire = 2'b00; i_done = 1'b1; step();
        i_done = 1'b0;
        chk(tag, 32'(bus.o_done), 32'(exp_done));
    endtask

    int g_order [5] = '{0, 1, 2, 3, 0};
    int drives;

    initial begin
        bus.i_addr = {10'h103, 10'h102, 10'h101, 10'h055};
        do_reset();

        // Reset state
        chk("rst_drive", 32'(o_drive), 0);
        chk("rst_gnt", 32'(bus.o_gnt), 0);
        chk("rst_done", 32'(bus.o_done), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_state", 32'(dbg_state), 0);

        // 1. Single request
        bus.i_req = 4'b0001; bus.i_we = 4'b0001;
        step();
        chk("t1_gnt", 32'(bus.o_gnt), 32'h1);
        chk("t1_drive", 32'(o_drive), 1);
        chk("t1_addr", 32'(o_addr), 32'h055);
        chk("t1_we", 32'(o_we), 1);
        bus.i_req = '0; bus.i_we = '0;
        step();
        chk("t1_wait_state", 32'(dbg_state), 2);
        chk("t1_drive_low", 32'(o_drive), 0);
        i_free = 1'b1; step(); i_free = 1'b0;
        chk("t1_busy_inflight", 32'(o_busy), 1);
        flush_one("t1_done", 4'b0001);
        chk("t1_busy_end", 32'(o_busy), 0);
        chk("t1_err", 32'(o_err), 0);

        // 2. Round-robin with the pipeline echoing every token
        bus.i_addr = {10'h103, 10'h102, 10'h101, 10'h100};
        do_reset();
        bus.i_req = 4'b1111;
        step();
        chk("t2_gnt0", 32'(bus.o_gnt), 32'h1);
        step(); i_free = 1'b1;
        step(); i_free = 1'b0;
        for (int n = 1; n < 5; n++) begin
            i_fire = 2'b01; step();
            chk($sformatf("t2_gnt%0d", n), 32'(bus.o_gnt), 32'(1 << g_order[n]));
            chk($sformatf("t2_addr%0d", n), 32'(o_addr), 32'(10'h100 + g_order[n]));
            i_fire = 2'b10; step();
            i_fire = 2'b00; i_done = 1'b1; i_free = 1'b1; step();
            i_done = 1'b0; i_free = 1'b0;
            chk($sformatf("t2_done%0d", n - 1), 32'(bus.o_done), 32'(1 << g_order[n - 1]));
        end
        bus.i_req = '0;
        flush_one("t2_done4", 4'b0001);
        chk("t2_busy", 32'(o_busy), 0);
        chk("t2_err", 32'(o_err), 0);

        // 3. Credit limit, pointer continues at 1
        bus.i_req = 4'b1111;
        step();
        chk("t3_gnt_a", 32'(bus.o_gnt), 32'h2);
        step(); i_free = 1'b1;
        step(); i_free = 1'b0;
        step();
        chk("t3_gnt_b", 32'(bus.o_gnt), 32'h4);
        step(); i_free = 1'b1;
        step(); i_free = 1'b0;
        chk("t3_inflight", 32'(dbg_inflight), 2);
        drives = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            drives += int'(o_drive);
        end
        chk("t3_no_launch", 32'(drives), 0);
        i_fire = 2'b01; step();
        i_fire = 2'b10; step();
        i_fire = 2'b00; i_done = 1'b1; step();
        i_done = 1'b0;
        chk("t3_done_a", 32'(bus.o_done), 32'h2);
        chk("t3_drive_blocked", 32'(o_drive), 0);
        step();
        chk("t3_third_drive", 32'(o_drive), 1);
        chk("t3_gnt_c", 32'(bus.o_gnt), 32'h8);
        step(); i_free = 1'b1;
        step(); i_free = 1'b0;
        bus.i_req = '0;
        flush_one("t3_done_b", 4'b0100);

        // 4. Launch and done in the same cycle with one token in flight
        i_fire = 2'b01; step();
        i_fire = 2'b10; step();
        i_fire = 2'b00;
        bus.i_req = 4'b0001;
        step();
        chk("t4_gnt", 32'(bus.o_gnt), 32'h1);
        bus.i_req = '0; i_done = 1'b1;
        step();
        i_done = 1'b0;
        chk("t4_done_oldest", 32'(bus.o_done), 32'h8);
        chk("t4_inflight", 32'(dbg_inflight), 1);
        i_free = 1'b1; step(); i_free = 1'b0;
        chk("t4_inflight_idle", 32'(dbg_inflight), 1);
        chk("t4_err", 32'(o_err), 0);
        flush_one("t4_done_new", 4'b0001);
        chk("t4_busy", 32'(o_busy), 0);

        // 5. Protocol errors
        i_done = 1'b1; step(); i_done = 1'b0;
        chk("t5_done_empty_pulse", 32'(bus.o_done), 0);
        chk("t5_done_empty_err", 32'(o_err), 1);
        step();
        chk("t5_err_sticky", 32'(o_err), 1);
        chk("t5_inflight", 32'(dbg_inflight), 0);
        do_reset();
        chk("t5_err_cleared", 32'(o_err), 0);
        i_fire = 2'b10; step(); i_fire = 2'b00;
        chk("t5_fire1_err", 32'(o_err), 1);
        step();
        chk("t5_fire1_no_done", 32'(bus.o_done), 0);

        // 6. Reset in WAIT_FREE with two tokens in flight
        do_reset();
        bus.i_req = 4'b1111; bus.i_we = 4'b0010;
        step();
        chk("t6_gnt0", 32'(bus.o_gnt), 32'h1);
        step(); i_free = 1'b1;
        step(); i_free = 1'b0;
        step();
        chk("t6_gnt1", 32'(bus.o_gnt), 32'h2);
        step();
        chk("t6_inflight", 32'(dbg_inflight), 2);
        chk("t6_state", 32'(dbg_state), 2);
        rst = 1'b0;
        #1;
        chk("t6_rst_drive", 32'(o_drive), 0);
        chk("t6_rst_gnt", 32'(bus.o_gnt), 0);
        chk("t6_rst_addr", 32'(o_addr), 0);
        chk("t6_rst_we", 32'(o_we), 0);
        chk("t6_rst_busy", 32'(o_busy), 0);
        chk("t6_rst_err", 32'(o_err), 0);
        chk("t6_rst_inflight", 32'(dbg_inflight), 0);
        step();
        rst = 1'b1;
        step();
        chk("t6_regrant", 32'(bus.o_gnt), 32'h1);
        chk("t6_regrant_addr", 32'(o_addr), 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_pipe_sched.md
Name: mem_pipe_sched

Overview:
- Synchronous scheduler that shares one two-stage click memory pipeline (sender, relay0, relay1, receiver) among N_REQ requesters.
- Arbitrates requests round-robin and launches one token per grant on the pipeline's drive input.
- Tracks in-flight tokens via the pipeline's free, fire and drive-out events, and returns a per-requester completion pulse.
- Sits between the synchronous request logic and the async control chain; all pipeline-side inputs arrive already synchronized to clk as single-cycle pulses.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 10, memory address width.
- MAX_INFLIGHT, 2, tokens allowed in the pipeline at once (1..2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- i_req  in  N_REQ  level request per requester; held until granted.
- i_addr  in  N_REQ*ADDR_W  per-requester address; slice k belongs to requester k.
- i_we  in  N_REQ  per-requester write enable.
- o_gnt  out  N_REQ  one-hot, one-cycle grant pulse.
- o_drive  out  1  one-cycle launch pulse to the pipeline drive input.
- o_addr  out  ADDR_W  address of the last launched token, held until the next launch.
- o_we  out  1  we of the last launched token, held until the next launch.
- i_free  in  1  pulse: pipeline accepted the launch (sender free).
- i_fire  in  2  pulses: bit0 = relay0 fired, bit1 = relay1 fired.
- i_done  in  1  pulse: token left the pipeline (driveNext).
- o_done  out  N_REQ  one-hot, one-cycle completion pulse to the owning requester.
- o_busy  out  1  high when inflight != 0 or FSM != IDLE.
- o_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=0, async): all outputs 0; FSM=IDLE; rr pointer=0; inflight=0; tag FIFO empty; stage occupancy s0=s1=0.
- FSM IDLE:
  - If any i_req and inflight<MAX_INFLIGHT, pick the first requesting index at or after the rr pointer.
  - Same cycle: register the winner's addr/we and push its index into the tag FIFO.
  - Next cycle: go to LAUNCH.
- FSM LAUNCH:
  - o_drive=1 and o_gnt[winner]=1 for exactly this cycle.
  - inflight+1; rr pointer = winner+1 mod N_REQ.
  - Go to WAIT_FREE.
- FSM WAIT_FREE:
  - Stay until i_free, then go to IDLE. No new launch while in WAIT_FREE.
  - i_free seen in IDLE or LAUNCH: set o_err, ignore.
- Grant latency: request sampled in IDLE produces o_gnt/o_drive 1 cycle later. Minimum launch spacing is 3 cycles (IDLE, LAUNCH, WAIT_FREE with i_free on its first cycle).
- Stage tracking:
  - i_fire[0] sets s0. Error if s0 was already 1.
  - i_fire[1] clears s0 and sets s1. Error if s0=0 or s1 was already 1.
  - i_done clears s1. Error if s1=0.
  - Events in the same cycle are applied in the order i_done, i_fire[1], i_fire[0].
- Completion: on i_done, pop the tag FIFO head k, pulse o_done[k] next cycle, inflight-1.
  - i_done with inflight=0 or an empty FIFO sets o_err; no o_done pulse and no count change.
- Simultaneous launch and i_done: inflight is unchanged, push and pop both happen, and FIFO order is preserved.
- inflight saturates: it never exceeds MAX_INFLIGHT and never underflows.
- Tag FIFO: depth MAX_INFLIGHT, width clog2(N_REQ), circular pointers wrap modulo depth, completes in launch order. Full prevents arbitration.
- o_err clears only on reset.
- Reset mid-operation: all state is dropped; requesters must re-assert i_req.

Decomposition:
- Shared package mem_pipe_pkg holds:
  - FSM state encoding IDLE=2'd0, LAUNCH=2'd1, WAIT_FREE=2'd2.
  - Constant TAG_W = clog2(N_REQ).
- One natural sub-module: rr_arbiter (N_REQ request vector and pointer in; one-hot grant and index out; combinational).
- The tag FIFO stays inline.

Test Plan:
1. Single request: i_req=4'b0001, addr=0x055, i_free 1 cycle after o_drive, fire0, fire1, done. Expect o_gnt=0001 1 cycle after sampling, o_addr=0x055, o_done=0001 1 cycle after i_done, o_busy back to 0, o_err=0.
2. Round-robin: i_req=4'b1111 held, pipeline echoes responses. Expect grant order 0,1,2,3,0 and o_done order matching it.
3. Credit limit: MAX_INFLIGHT=2, i_done withheld. Expect exactly 2 launches, then no o_drive until i_done; 3rd launch within 2 cycles of i_done.
4. Simultaneous launch and done with inflight=1. Expect inflight stays 1 and o_done goes to the oldest tag.
5. Protocol errors: i_done with inflight=0, and i_fire[1] without a prior i_fire[0]. Expect o_err=1 and no o_done pulse.
6. Reset asserted in WAIT_FREE with inflight=2. Expect all outputs 0 immediately; after release, a new request is granted by requester index starting from 0.
